btn_pulse_gen: RTL

//  Upstream stage of led_test: turns a raw, bouncing push-button into a clean

---
 rtl/sp_pkg.sv | 14 +
 rtl/sync_2ff.sv | 25 ++
 rtl/btn_pulse_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/sp_pkg.sv
// Shared types and defaults for the push-button front end.
package sp_pkg;

  // Bit 1 of the encoding is the debounced level, so level_o is a direct flop output.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARM_PRESS = 2'b01,
    HELD      = 2'b10,
    ARM_REL   = 2'b11
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounces a raw push-button into a clean level and one pulse per accepted press,
// and counts accepted presses.
module btn_pulse_gen
  import sp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int PCNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_i,
  output logic              pulse_o,
  output logic              level_o,
  output logic [PCNT_W-1:0] press_cnt_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_pulse_gen: DEBOUNCE_CYCLES must be >= 1");
  end

  logic btn_p, btn_s;

  // Normalise polarity before the synchroniser so reset value 0 means "not pressed".
  assign btn_p = BTN_ACTIVE_LOW ? ~btn_i : btn_i;

  sync_2ff #(
    .RST_VAL(1'b0)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (btn_p),
    .q_o   (btn_s)
  );

  btn_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic [PCNT_W-1:0] press_cnt_q, press_cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_d     = 1'b0;
    press_cnt_d = press_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = ARM_PRESS;
          cnt_d   = '0;
        end
      end
      ARM_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = HELD;
          pulse_d     = 1'b1;
          press_cnt_d = press_cnt_q + PCNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = ARM_REL;
          cnt_d   = '0;
        end
      end
      ARM_REL: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign pulse_o     = pulse_q;
  assign level_o     = (state_q == HELD) || (state_q == ARM_REL);
  assign press_cnt_o = press_cnt_q;

endmodule
